// File: rtl/cic_pkg.sv
// Shared types and defaults for the CIC decimator run-control block.
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } cic_ctrl_state_t;

    // A SMALL_FOOTPRINT comb needs more than CIC_N clocks per output sample.
    function automatic int unsigned min_out_gap_default(input int unsigned cic_n);
        return cic_n + 2;
    endfunction

endpackage

// File: rtl/cic_str_gap_mon.sv
// Filter output strobe spacing monitor with a sticky overrun flag.
module cic_str_gap_mon #(
    parameter int unsigned MIN_OUT_GAP = 9,
    parameter int unsigned CW          = $clog2(MIN_OUT_GAP + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic str,
    input  logic arm,
    input  logic clr,
    output logic overrun
);

    localparam logic [CW-1:0] GAP_SAT = CW'(MIN_OUT_GAP);
    localparam logic [CW-1:0] GAP_LIM = CW'((MIN_OUT_GAP > 0) ? MIN_OUT_GAP - 1 : 0);

    logic [CW-1:0] cnt;
    logic          valid;
    logic          viol;

    // cnt holds clocks since the last strobe minus one, so gap < MIN is cnt < MIN-1.
    assign viol = arm && str && valid && (cnt < GAP_LIM);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (!arm) begin
                cnt   <= '0;
                valid <= 1'b0;
            end else if (str) begin
                cnt   <= '0;
                valid <= 1'b1;
            end else if (cnt != GAP_SAT) begin
                cnt <= cnt + CW'(1);
            end

            if (viol) begin
                overrun <= 1'b1;
            end else if (clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cic_d_ctrl.sv
// Run-control sequencer around a cic_d decimator: flush, settle discard, run, gap monitor.
module cic_d_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned INP_DW         = 18,
    parameter int unsigned OUT_DW         = 18,
    parameter int unsigned CIC_N          = 7,
    parameter int unsigned FLUSH_CYCLES   = CIC_N + 2,
    parameter int unsigned SETTLE_SAMPLES = CIC_N,
    parameter int unsigned MIN_OUT_GAP    = min_out_gap_default(CIC_N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clr_overrun,
    input  logic [INP_DW-1:0] inp_samp_data,
    input  logic              inp_samp_str,
    output logic              cic_reset_n,
    output logic [INP_DW-1:0] cic_inp_samp_data,
    output logic              cic_inp_samp_str,
    input  logic [OUT_DW-1:0] cic_out_samp_data,
    input  logic              cic_out_samp_str,
    output logic [OUT_DW-1:0] out_samp_data,
    output logic              out_samp_str,
    output logic [1:0]        state,
    output logic              overrun,
    output logic [31:0]       out_cnt
);

    localparam int unsigned FW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned SW = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES);
    localparam int unsigned GW = (MIN_OUT_GAP < 2) ? 1 : $clog2(MIN_OUT_GAP + 1);

    localparam logic [FW-1:0] FLUSH_LOAD  = FW'(FLUSH_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    cic_ctrl_state_t st;
    cic_ctrl_state_t nxt;

    logic [FW-1:0] flush_cnt;
    logic [SW-1:0] settle_cnt;
    logic          active;
    logic          deliver;

    assign state = st;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE: begin
                if (enable) nxt = FLUSH;
            end
            FLUSH: begin
                if (!enable) begin
                    nxt = IDLE;
                end else if (flush_cnt == FW'(1)) begin
                    nxt = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    nxt = IDLE;
                end else if (cic_out_samp_str && (settle_cnt == SETTLE_LAST)) begin
                    nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Decoded from the state register only, so the filter reset cannot glitch.
    always_comb begin
        active      = (st == SETTLE) || (st == RUN);
        deliver     = (st == RUN);
        cic_reset_n = active;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flush_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            if (st == IDLE) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (st == FLUSH) begin
                flush_cnt <= flush_cnt - FW'(1);
            end

            if (st != SETTLE) begin
                settle_cnt <= '0;
            end else if (cic_out_samp_str) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cic_inp_samp_str  <= 1'b0;
            cic_inp_samp_data <= '0;
            out_samp_str      <= 1'b0;
            out_samp_data     <= '0;
            out_cnt           <= '0;
        end else begin
            cic_inp_samp_str <= active && inp_samp_str;
            if (active && inp_samp_str) begin
                cic_inp_samp_data <= inp_samp_data;
            end

            out_samp_str <= deliver && cic_out_samp_str;
            if (deliver && cic_out_samp_str) begin
                out_samp_data <= cic_out_samp_data;
                out_cnt       <= out_cnt + 32'd1;
            end
        end
    end

    cic_str_gap_mon #(
        .MIN_OUT_GAP (MIN_OUT_GAP),
        .CW          (GW)
    ) u_gap_mon (
        .clk     (clk),
        .reset_n (reset_n),
        .str     (cic_out_samp_str),
        .arm     (active),
        .clr     (clr_overrun),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_cic_d_ctrl.sv
// Scoreboard bench for cic_d_ctrl: default instance plus a SETTLE_SAMPLES=0 instance.
module tb_cic_d_ctrl;

    typedef struct {
        logic [17:0] data;
        logic [31:0] cnt;
    } out_exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clr_overrun;
    logic [17:0] inp_samp_data;
    logic        inp_samp_str;
    logic        cic_reset_n;
    logic [17:0] cic_inp_samp_data;
    logic        cic_inp_samp_str;
    logic [17:0] cic_out_samp_data;
    logic        cic_out_samp_str;
    logic [17:0] out_samp_data;
    logic        out_samp_str;
    logic [1:0]  state;
    logic        overrun;
    logic [31:0] out_cnt;

    logic        z_enable;
    logic        z_clr_overrun;
    logic [17:0] z_inp_samp_data;
    logic        z_inp_samp_str;
    logic        z_cic_reset_n;
    logic [17:0] z_cic_inp_samp_data;
    logic        z_cic_inp_samp_str;
    logic [17:0] z_cic_out_samp_data;
    logic        z_cic_out_samp_str;
    logic [17:0] z_out_samp_data;
    logic        z_out_samp_str;
    logic [1:0]  z_state;
    logic        z_overrun;
    logic [31:0] z_out_cnt;

    int checks   = 0;
    int failures = 0;
    int low;

    out_exp_t    oq[$];
    logic [17:0] iq[$];
    out_exp_t    oe;
    logic [17:0] ie;

    always #5 clk = ~clk;

    cic_d_ctrl u_dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .clr_overrun       (clr_overrun),
        .inp_samp_data     (inp_samp_data),
        .inp_samp_str      (inp_samp_str),
        .cic_reset_n       (cic_reset_n),
        .cic_inp_samp_data (cic_inp_samp_data),
        .cic_inp_samp_str  (cic_inp_samp_str),
        .cic_out_samp_data (cic_out_samp_data),
        .cic_out_samp_str  (cic_out_samp_str),
        .out_samp_data     (out_samp_data),
        .out_samp_str      (out_samp_str),
        .state             (state),
        .overrun           (overrun),
        .out_cnt           (out_cnt)
    );

    cic_d_ctrl #(
        .SETTLE_SAMPLES (0)
    ) u_dut0 (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (z_enable),
        .clr_overrun       (z_clr_overrun),
        .inp_samp_data     (z_inp_samp_data),
        .inp_samp_str      (z_inp_samp_str),
        .cic_reset_n       (z_cic_reset_n),
        .cic_inp_samp_data (z_cic_inp_samp_data),
        .cic_inp_samp_str  (z_cic_inp_samp_str),
        .cic_out_samp_data (z_cic_out_samp_data),
        .cic_out_samp_str  (z_cic_out_samp_str),
        .out_samp_data     (z_out_samp_data),
        .out_samp_str      (z_out_samp_str),
        .state             (z_state),
        .overrun           (z_overrun),
        .out_cnt           (z_out_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_out(input logic [17:0] d);
        cic_out_samp_data = d;
        cic_out_samp_str  = 1'b1;
        tick();
        cic_out_samp_str  = 1'b0;
    endtask

    // Called just after the edge that samples enable=1.
    task automatic measure_flush();
        low = 0;
        while (cic_reset_n == 1'b0 && low < 50) begin
            chk("flush_state", 32'(state), 32'd1);
            low++;
            tick();
        end
        chk("flush_len", low, 32'd9);
        chk("after_flush_state", 32'(state), 32'd2);
    endtask

    task automatic settle(input logic [17:0] base);
        for (int i = 1; i <= 7; i++) begin
            pulse_out(base + 18'(i));
            chk("settle_state", 32'(state), (i == 7) ? 32'd3 : 32'd2);
            idle(9);
        end
    endtask

    always @(negedge clk) begin
        if (out_samp_str) begin
            if (oq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected actual=%0h required=none", out_samp_data);
            end else begin
                oe = oq.pop_front();
                chk("out_data", 32'(out_samp_data), 32'(oe.data));
                chk("out_cnt_sb", out_cnt, oe.cnt);
            end
        end
        if (cic_inp_samp_str) begin
            if (iq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL inp_unexpected actual=%0h required=none", cic_inp_samp_data);
            end else begin
                ie = iq.pop_front();
                chk("inp_data", 32'(cic_inp_samp_data), 32'(ie));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; clr_overrun = 1'b0;
        inp_samp_data = '0; inp_samp_str = 1'b0;
        cic_out_samp_data = '0; cic_out_samp_str = 1'b0;
        z_enable = 1'b0; z_clr_overrun = 1'b0;
        z_inp_samp_data = '0; z_inp_samp_str = 1'b0;
        z_cic_out_samp_data = '0; z_cic_out_samp_str = 1'b0;
        idle(3);

        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cic_reset_n", 32'(cic_reset_n), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_out_cnt", out_cnt, 32'd0);
        chk("rst_out_str", 32'(out_samp_str), 32'd0);
        chk("rst_out_data", 32'(out_samp_data), 32'd0);
        chk("rst_inp_str", 32'(cic_inp_samp_str), 32'd0);
        chk("rst_inp_data", 32'(cic_inp_samp_data), 32'd0);
        chk("rst_z_state", 32'(z_state), 32'd0);

        reset_n = 1'b1;
        idle(2);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_cic_reset_n", 32'(cic_reset_n), 32'd0);

        enable = 1'b1;
        tick();
        measure_flush();

        settle(18'd0);
        chk("settle_overrun", 32'(overrun), 32'd0);
        chk("settle_out_cnt", out_cnt, 32'd0);

        oq.push_back('{data: 18'd8, cnt: 32'd1});
        pulse_out(18'd8);
        chk("first_out_str", 32'(out_samp_str), 32'd1);
        chk("first_out_cnt", out_cnt, 32'd1);
        chk("run_state", 32'(state), 32'd3);

        for (int k = 0; k < 3; k++) begin
            inp_samp_data = 18'h100 + 18'(k);
            inp_samp_str  = 1'b1;
            iq.push_back(18'h100 + 18'(k));
            tick();
        end
        inp_samp_data = 18'h200;
        enable        = 1'b0;
        iq.push_back(18'h200);
        tick();
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_cic_reset_n", 32'(cic_reset_n), 32'd0);
        for (int k = 0; k < 3; k++) begin
            inp_samp_data = 18'h300 + 18'(k);
            tick();
            chk("stop_inp_str", 32'(cic_inp_samp_str), 32'd0);
        end
        inp_samp_str = 1'b0;

        enable = 1'b1;
        tick();
        measure_flush();
        chk("restart_out_cnt", out_cnt, 32'd1);
        settle(18'h10);

        oq.push_back('{data: 18'hA1, cnt: 32'd2});
        pulse_out(18'hA1);
        chk("wide_gap_overrun", 32'(overrun), 32'd0);
        idle(4);
        oq.push_back('{data: 18'hB2, cnt: 32'd3});
        pulse_out(18'hB2);
        chk("short_gap_overrun", 32'(overrun), 32'd1);
        tick();
        chk("sticky_overrun", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("clr_overrun", 32'(overrun), 32'd0);
        idle(2);
        clr_overrun = 1'b1;
        oq.push_back('{data: 18'hC3, cnt: 32'd4});
        pulse_out(18'hC3);
        clr_overrun = 1'b0;
        chk("set_wins_overrun", 32'(overrun), 32'd1);
        chk("run_out_cnt", out_cnt, 32'd4);

        enable  = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_cic_reset_n", 32'(cic_reset_n), 32'd0);
        chk("mid_rst_out_cnt", out_cnt, 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_out_str", 32'(out_samp_str), 32'd0);
        chk("mid_rst_out_data", 32'(out_samp_data), 32'd0);
        chk("mid_rst_inp_data", 32'(cic_inp_samp_data), 32'd0);

        z_enable = 1'b1;
        tick();
        chk("z_flush_state", 32'(z_state), 32'd1);
        idle(8);
        chk("z_last_flush_state", 32'(z_state), 32'd1);
        chk("z_last_flush_rst", 32'(z_cic_reset_n), 32'd0);
        z_inp_samp_data = 18'h77;
        z_inp_samp_str  = 1'b1;
        tick();
        z_inp_samp_str  = 1'b0;
        chk("z_direct_run", 32'(z_state), 32'd3);
        chk("z_cic_reset_n", 32'(z_cic_reset_n), 32'd1);
        chk("z_exit_inp_dropped", 32'(z_cic_inp_samp_str), 32'd0);
        z_cic_out_samp_data = 18'h55;
        z_cic_out_samp_str  = 1'b1;
        tick();
        z_cic_out_samp_str  = 1'b0;
        chk("z_first_out_str", 32'(z_out_samp_str), 32'd1);
        chk("z_first_out_data", 32'(z_out_samp_data), 32'h55);
        chk("z_first_out_cnt", z_out_cnt, 32'd1);
        z_inp_samp_data = 18'h66;
        z_inp_samp_str  = 1'b1;
        tick();
        z_inp_samp_str  = 1'b0;
        chk("z_inp_str", 32'(z_cic_inp_samp_str), 32'd1);
        chk("z_inp_data", 32'(z_cic_inp_samp_data), 32'h66);

        idle(2);
        chk("out_queue_empty", 32'(oq.size()), 32'd0);
        chk("inp_queue_empty", 32'(iq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_d_ctrl.md
# cic_d_ctrl

Run-control sequencer placed in front of and behind one `cic_d` decimator instance. On `enable` it holds the filter in reset long enough to clear all integrator and comb state, then forwards input samples. It discards the start-up transient output samples and delivers only settled decimated samples downstream. It also monitors the spacing of the filter's output strobes and raises a sticky `overrun` when the SMALL_FOOTPRINT comb timing budget (more than CIC_N clocks per output sample) is violated.

## Interface
- `INP_DW`, 18, input sample width.
- `OUT_DW`, 18, output sample width.
- `CIC_N`, 7, number of CIC stages in the controlled filter.
- `FLUSH_CYCLES`, CIC_N+2, number of cycles `cic_reset_n` is held low per start; must be ≥1.
- `SETTLE_SAMPLES`, CIC_N, number of filter output samples discarded after a flush; 0 is allowed.
- `MIN_OUT_GAP`, CIC_N+2, minimum number of clocks between filter output strobes; back-to-back strobes count as a gap of 1.

Ports:
- `clk`, in, 1, the single clock.
- `reset_n`, in, 1, reset; synchronous, active-low.
- `enable`, in, 1, level; 1 runs the filter, 0 stops it.
- `clr_overrun`, in, 1, pulse that clears `overrun`.
- `inp_samp_data`, in, INP_DW, upstream sample.
- `inp_samp_str`, in, 1, upstream sample strobe.
- `cic_reset_n`, out, 1, reset to the filter.
- `cic_inp_samp_data`, out, INP_DW, sample to the filter.
- `cic_inp_samp_str`, out, 1, strobe to the filter.
- `cic_out_samp_data`, in, OUT_DW, filter output sample.
- `cic_out_samp_str`, in, 1, filter output strobe.
- `out_samp_data`, out, OUT_DW, settled output sample.
- `out_samp_str`, out, 1, settled output strobe.
- `state`, out, 2, current state: IDLE=0, FLUSH=1, SETTLE=2, RUN=3.
- `overrun`, out, 1, sticky flag for a strobe-spacing violation.
- `out_cnt`, out, 32, count of delivered samples; wraps from 2^32−1 to 0.

## Operation
- **Reset values:** `state`=IDLE, `cic_reset_n`=0, all strobes 0, all data 0, `overrun`=0, `out_cnt`=0.
- **IDLE**
  - Drives `cic_reset_n`=0.
  - Drops all input and filter-output strobes.
  - `enable`=1 → FLUSH, with the flush counter loaded to FLUSH_CYCLES.
- **FLUSH**
  - Drives `cic_reset_n`=0.
  - The counter decrements each cycle; at count 1 → SETTLE, or → RUN if SETTLE_SAMPLES=0.
- **SETTLE**
  - Drives `cic_reset_n`=1 and forwards input strobes.
  - Each `cic_out_samp_str` increments the discard counter and produces no output.
  - The SETTLE_SAMPLES-th discard → RUN.
- **RUN**
  - Forwards input strobes.
  - Each `cic_out_samp_str` produces an `out_samp_str` and increments `out_cnt`.
- **Stop and restart**
  - `enable`=0 in any non-IDLE state → IDLE on the next cycle.
  - A restart always passes through the full FLUSH.
  - `out_cnt` is not cleared by stop or restart, only by `reset_n`.
- **`cic_reset_n` generation:** a pure decode of the state register (1 in SETTLE or RUN), so it is glitch-free.
- **Gap monitor**
  - A saturating counter counts clocks since the last `cic_out_samp_str`.
  - It is cleared on each strobe and marked invalid in IDLE and FLUSH.
  - A strobe in SETTLE or RUN with a valid gap < MIN_OUT_GAP sets `overrun`.
  - The first strobe after a flush is never checked.
  - If `overrun` is set and `clr_overrun` is asserted in the same cycle, set wins.
- **Data path:** data is passed unchanged; no arithmetic or width change.

## Timing
- **Input path latency:** `inp_samp_str` in cycle c while `state` is SETTLE or RUN → `cic_inp_samp_str`=1 in cycle c+1, with data registered alongside.
- **Output path latency:** `cic_out_samp_str` in cycle c while in RUN → `out_samp_str` in c+1; `out_cnt` updates in c+1.
- **Start timing:** `enable` sampled high at edge t → FLUSH from t+1 → `cic_reset_n` rises at t+1+FLUSH_CYCLES.
- **Transition-cycle strobes:** strobes arriving in the cycle `state` leaves FLUSH are dropped, because the decision uses the registered state.
- **Strobe on the SETTLE→RUN cycle:** the strobe that completes the discard count is itself discarded.
- **Stop timing:** `enable` low at edge t → `state`=IDLE and `cic_reset_n`=0 from t+1. No strobe is emitted from t+1 on, except one already registered at t.
- **`reset_n` mid-operation:** everything returns to its reset value on the next edge; `cic_reset_n`=0.

## Structure
- **Shared package `cic_pkg`:** holds the typedef enum `cic_ctrl_state_t` (IDLE, FLUSH, SETTLE, RUN; 2 bits) and the `MIN_OUT_GAP` default function.
- **Sub-module `cic_str_gap_mon`:** the gap counter, validity flag, and sticky `overrun` logic. Parameters are MIN_OUT_GAP and the counter width (clog2 of MIN_OUT_GAP+1). Inputs are `str`, `arm`, and `clr`.
- **Top level:** the FSM, counters, and registered strobe/data gates.

## Test plan
- **Flush length:** reset, then `enable`=1 with CIC_N=7 defaults → `cic_reset_n` low for exactly 9 cycles, then high; `state` sequence 0,1,2.
- **Settle discard:** in SETTLE, drive 7 `cic_out_samp_str` pulses with data 1..7, then pulse 8 with data 8 → `out_samp_str` only for 8, one cycle after; `out_cnt`=1; `state`=3.
- **Stop and restart:** deassert `enable` in RUN while input strobes continue → `cic_inp_samp_str` stops from the next cycle. Re-enable → full 9-cycle flush recurs and `out_cnt` is kept.
- **Overrun:** in RUN, two filter strobes 5 clocks apart → `overrun`=1 and stays set. Assert `clr_overrun` alone → 0. A further strobe 5 clocks after the last one while `clr_overrun`=1 → remains 1.
- **Edge parameters:** SETTLE_SAMPLES=0 → FLUSH goes directly to RUN and the first filter strobe is delivered. Also an input strobe on the FLUSH-exit cycle → not forwarded.
- **Mid-run reset:** `reset_n`=0 for 1 cycle mid-RUN → all outputs zero, `state`=0, `out_cnt`=0 next cycle.
